// File: rtl/mem_ctrl_defs_pkg.sv
// Shared definitions for the MEM-stage controller: state encodings, abort data, default widths.
// Optional MEM_TIMEOUT_EN build uses ABORT_DATA as the load result on an aborted access.
package mem_ctrl_defs;

  localparam int DATA_W_DEF         = 32;
  localparam int ADDR_W_DEF         = 32;
  localparam int TIMEOUT_CYCLES_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Clear/enable counter flagging expiry when the count reaches LIMIT-1; expiry is combinational.
// Used only in the MEM_TIMEOUT_EN build of mem_stage_ctrl.
module mem_timeout_cnt #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: IDLE -> ACCESS (req held until ack) -> DONE; stalls upstream and bubbles MEM/WB meanwhile.
// MEM_TIMEOUT_EN adds an abort after TIMEOUT_CYCLES ACCESS cycles with a one-cycle mem_err pulse.
module mem_stage_ctrl
  import mem_ctrl_defs::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] read_data_out,
  output logic              stall,
  output logic              memwb_bubble,
  output logic              mem_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t state, state_nxt;
  logic   op;
  logic   launch;
  logic   capture;
  logic   abort;
  logic   timeout_hit;

  assign op = mem_read_in | mem_write_in;

  always_comb begin
    state_nxt    = ST_IDLE;
    stall        = 1'b0;
    memwb_bubble = 1'b0;
    launch       = 1'b0;
    capture      = 1'b0;
    abort        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op) begin
          stall        = 1'b1;
          memwb_bubble = 1'b1;
          launch       = 1'b1;
          state_nxt    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall        = 1'b1;
        memwb_bubble = 1'b1;
        // A late ack on the expiry cycle still completes the access normally.
        if (dmem_ack) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      read_data_out <= '0;
    end else begin
      state <= state_nxt;
      if (launch) begin
        dmem_req   <= 1'b1;
        dmem_we    <= mem_write_in;
        dmem_addr  <= addr_in;
        dmem_wdata <= wdata_in;
      end
      if (capture) begin
        dmem_req      <= 1'b0;
        read_data_out <= dmem_rdata;
      end else if (abort) begin
        dmem_req      <= 1'b0;
        read_data_out <= DATA_W'(ABORT_DATA);
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (launch),
    .en      ((state == ST_ACCESS) && !dmem_ack),
    .expired (timeout_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= abort;
    end
  end

  assign mem_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_err     = 1'b0;
`endif

endmodule
